bloke2_digest_capture: RTL
==========================

// Module: bloke2_digest_capture
// PURPOSE
//   Downstream stage of the BLAKE2 hash core (bloke2s/bloke2b wrappers).
//   - Consumes the core's serial digest byte stream (dout/dout_valid/dout_end).
//   - Assembles the bytes into a parallel digest register.
//   - Checks digest length and compares the result against an expected digest.
//   - Flags done/match/error to the surrounding control logic.
// PARAMETERS
//   OUT_BYTES  32  digest length in bytes (32 for BLAKE2s, 64 for BLAKE2b)
//   CNT_W      7   byte counter width; must satisfy 2**CNT_W > OUT_BYTES
// PORTS
//   clk        in   1              clock
//   rst_n      in   1              synchronous reset, active-low
//   start      in   1              clear and arm for a new digest
//   din        in   8              digest byte (connect to hash dout)
//   din_valid  in   1              byte strobe (connect to hash dout_valid)
//   din_end    in   1              last byte, qualified by din_valid (hash dout_end)
//   expected   in   8*OUT_BYTES    reference digest; byte i at [8i+7:8i]
//   digest     out  8*OUT_BYTES    captured digest; byte i at [8i+7:8i]
//   busy       out  1              high in COLLECT state
//   done       out  1              capture finished; sticky
//   match      out  1              digest==expected, length correct, no error; sticky
//   err        out  1              overrun or short digest; sticky
// BEHAVIOUR
//   Reset and accept rules
//   - Reset (rst_n==0 at clk edge):
//     - state=IDLE; count=0.
//     - digest, busy, done, match and err all read 0.
//   - No backpressure. Every din_valid byte is accepted or discarded in the
//     same cycle.
//   States
//   - IDLE: din_valid/din_end ignored.
//     - start=1 -> COLLECT.
//   - COLLECT, on din_valid=1:
//     - count<OUT_BYTES: digest byte[count]<=din; count<=count+1.
//     - count==OUT_BYTES: byte discarded; err<=1 (overrun). The counter saturates.
//     - din_end=1 with the valid byte: state->DONE. Next cycle: done=1;
//       match = (digest incl. this byte == expected) && (count+1==OUT_BYTES) && !err.
//     - Short digest (end byte with count+1<OUT_BYTES): err<=1; match=0.
//   - DONE: holds digest, done, match and err.
//     - din_valid ignored.
//     - start=1 -> COLLECT.
//   Edge cases and timing
//   - din_end without din_valid is ignored in all states.
//   - start in any state (including mid-COLLECT) clears digest, count, done,
//     match and err, then enters COLLECT next cycle.
//     - start has priority over din_valid in the same cycle; that byte is dropped.
//   - Latency: done and match rise exactly 1 cycle after the end byte is accepted.
//   - expected is sampled only in the end-byte cycle.
//   - busy = (state==COLLECT); registered, rises the cycle after start.
//   - Byte order: the first byte received lands in digest[7:0], matching BLAKE2
//     little-endian output.
// CONFIGURATION
//   BLOKE2_CAPTURE_READBACK_EN
//   - Defined: adds ports
//       rd_idx   in   CNT_W  byte index to read
//       rd_byte  out  8      digest byte[rd_idx]
//     - rd_byte is registered: 1-cycle latency, reset 0.
//     - rd_idx>=OUT_BYTES returns 8'h00.
//   - Undefined: rd_idx/rd_byte ports are absent. No readback logic.
// TESTING
//   1. Drive 32 bytes 0x00..0x1F, end on the last; expected = same
//      -> done=1, match=1, err=0 one cycle later; digest[7:0]=00, digest[255:248]=1F.
//   2. Same stream, expected byte 5 = 0xFF -> done=1, match=0, err=0.
//   3. End asserted on byte 31 of 32 (31 bytes)
//      -> done=1, err=1, match=0.
//   4. 33 bytes, end on the 33rd -> err=1, match=0; digest holds the first 32 bytes.
//   5. start pulsed after 10 bytes, then a full valid 32-byte stream
//      -> match=1; no residue from the first 10 bytes.
//   6. READBACK_EN: after test 1, rd_idx=3 -> rd_byte=0x03 next cycle;
//      rd_idx=40 -> 0x00.
//      Also: rst_n low mid-COLLECT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bloke2_digest_capture.sv
// Captures the BLAKE2 serial digest byte stream into a parallel register and checks it against a reference.
// Optional readback port enabled by defining BLOKE2_CAPTURE_READBACK_EN.
module bloke2_digest_capture #(
    parameter int unsigned OUT_BYTES = 32,
    parameter int unsigned CNT_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    input  logic                   din_end,
    input  logic [8*OUT_BYTES-1:0] expected,
`ifdef BLOKE2_CAPTURE_READBACK_EN
    input  logic [CNT_W-1:0]       rd_idx,
    output logic [7:0]             rd_byte,
`endif
    output logic [8*OUT_BYTES-1:0] digest,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output logic                   err
);

    localparam int unsigned DW = 8 * OUT_BYTES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    digest_q, digest_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic             err_q, err_d;

    // Next-state: start clears and re-arms, and outranks any byte arriving in the same cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        digest_d = digest_q;
        done_d   = done_q;
        match_d  = match_q;
        err_d    = err_q;

        if (start) begin
            state_d  = COLLECT;
            count_d  = '0;
            digest_d = '0;
            done_d   = 1'b0;
            match_d  = 1'b0;
            err_d    = 1'b0;
        end else if (state_q == COLLECT && din_valid) begin
            if (count_q < CNT_W'(OUT_BYTES)) begin
                for (int i = 0; i < OUT_BYTES; i++) begin
                    if (count_q == CNT_W'(i)) begin
                        digest_d[8*i +: 8] = din;
                    end
                end
                count_d = count_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end

            if (din_end) begin
                state_d = DONE;
                done_d  = 1'b1;
                if (count_q < CNT_W'(OUT_BYTES - 1)) begin
                    err_d = 1'b1;
                end
                // Compare including the byte landing this cycle; only a clean exact-length stream matches.
                match_d = (digest_d == expected) &&
                          (count_q == CNT_W'(OUT_BYTES - 1)) && !err_q;
            end
        end

        busy_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            digest_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            digest_q <= digest_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
            err_q    <= err_d;
        end
    end

    assign digest = digest_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign match  = match_q;
    assign err    = err_q;

`ifdef BLOKE2_CAPTURE_READBACK_EN
    logic [7:0] rd_byte_q, rd_byte_d;

    // Out-of-range indices fall through to zero.
    always_comb begin
        rd_byte_d = 8'h00;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_byte_d = digest_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_byte_q <= 8'h00;
        end else begin
            rd_byte_q <= rd_byte_d;
        end
    end

    assign rd_byte = rd_byte_q;
`endif

endmodule
